// File: rtl/xv_pkg.sv
// Shared Xosera VRAM types: address/data words, requester ownership tags
// and the rotation helper used by the VRAM scheduler.
package xv;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_REGS = 2'd1,
        OWN_BLIT = 2'd2,
        OWN_DRAW = 2'd3
    } vram_owner_t;

    localparam int NUM_REQ = 3;

    // Rotation order regs(0) -> blit(1) -> draw(2) -> regs; 3 folds back to regs.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/vram_rr_pick.sv
// Combinational 3-way rotating priority picker: the first requester at or
// after ptr wins; outputs a one-hot grant and the matching owner tag.
module vram_rr_pick
    import xv::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] owner
);

    logic [3:0] req_ext;
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    logic [1:0] pick;
    logic       found;

    assign req_ext = {1'b0, req};
    assign first   = (ptr == 2'd3) ? 2'd0 : ptr;
    assign second  = rr_next(first);
    assign third   = rr_next(second);

    always_comb begin
        grant = 3'b000;
        owner = OWN_NONE;
        pick  = first;
        found = 1'b1;
        if (req_ext[first]) begin
            pick = first;
        end else if (req_ext[second]) begin
            pick = second;
        end else if (req_ext[third]) begin
            pick = third;
        end else begin
            found = 1'b0;
        end
        if (found) begin
            grant = 3'b001 << pick;
            owner = pick + 2'd1;
        end
    end

endmodule

// File: rtl/vram_sched.sv
// Single-port VRAM access scheduler: vgen has absolute priority, regs/blit/draw
// share the remaining slots round-robin through a two-stage access pipeline.
module vram_sched
    import xv::*;
#(
    parameter bit EN_BLIT = 1'b1,
    parameter bit EN_DRAW = 1'b0,
    parameter int WAIT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              vgen_sel_i,
    input  logic [15:0]       vgen_addr_i,
    input  logic              regs_sel_i,
    input  logic              regs_wr_i,
    input  logic [3:0]        regs_wr_mask_i,
    input  logic [15:0]       regs_addr_i,
    input  logic [15:0]       regs_data_i,
    output logic              regs_ack_o,
    input  logic              blit_sel_i,
    input  logic              blit_wr_i,
    input  logic [3:0]        blit_wr_mask_i,
    input  logic [15:0]       blit_addr_i,
    input  logic [15:0]       blit_data_i,
    output logic              blit_ack_o,
    input  logic              draw_sel_i,
    input  logic              draw_wr_i,
    input  logic [3:0]        draw_wr_mask_i,
    input  logic [15:0]       draw_addr_i,
    input  logic [15:0]       draw_data_i,
    output logic              draw_ack_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [3:0]        vram_wr_mask_o,
    output logic [15:0]       vram_addr_o,
    output logic [15:0]       vram_wdata_o,
    input  logic [15:0]       vram_rdata_i,
    output logic [15:0]       rd_data_o,
    output logic [1:0]        rd_owner_o,
    output logic              vgen_rd_valid_o,
    output logic [WAIT_W-1:0] regs_wait_o
);

    logic [2:0]        req;
    logic [2:0]        grant;
    logic [1:0]        pick_owner;
    logic              regs_granted;
    logic              win_wr;
    logic [3:0]        win_mask;
    addr_t             win_addr;
    word_t             win_data;

    logic              sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [3:0]        mask_q, mask_d;
    addr_t             addr_q, addr_d;
    word_t             wdata_q, wdata_d;
    logic [2:0]        ack_q, ack_d;
    logic [1:0]        ptr_q, ptr_d;
    vram_owner_t       tag_owner_q, tag_owner_d;
    logic              tag_vgen_q, tag_vgen_d;
    vram_owner_t       rd_owner_q;
    logic              rd_vgen_q;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // A requester whose ack is high this cycle sits out, which leaves the gap for others.
    assign req = {draw_sel_i & EN_DRAW & ~ack_q[2],
                  blit_sel_i & EN_BLIT & ~ack_q[1],
                  regs_sel_i & ~ack_q[0]};

    vram_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .owner (pick_owner)
    );

    assign regs_granted = grant[0] & ~vgen_sel_i;

    always_comb begin
        win_wr   = regs_wr_i;
        win_mask = regs_wr_mask_i;
        win_addr = regs_addr_i;
        win_data = regs_data_i;
        unique case (grant)
            3'b010: begin
                win_wr   = blit_wr_i;
                win_mask = blit_wr_mask_i;
                win_addr = blit_addr_i;
                win_data = blit_data_i;
            end
            3'b100: begin
                win_wr   = draw_wr_i;
                win_mask = draw_wr_mask_i;
                win_addr = draw_addr_i;
                win_data = draw_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_d       = 1'b0;
        wr_d        = 1'b0;
        mask_d      = mask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack_d       = 3'b000;
        ptr_d       = ptr_q;
        tag_owner_d = OWN_NONE;
        tag_vgen_d  = 1'b0;
        if (vgen_sel_i) begin
            sel_d      = 1'b1;
            mask_d     = 4'h0;
            addr_d     = vgen_addr_i;
            tag_vgen_d = 1'b1;
        end else if (|grant) begin
            sel_d       = 1'b1;
            wr_d        = win_wr;
            mask_d      = win_mask;
            addr_d      = win_addr;
            wdata_d     = win_data;
            ack_d       = grant;
            ptr_d       = rr_next(pick_owner - 2'd1);
            tag_owner_d = win_wr ? OWN_NONE : vram_owner_t'(pick_owner);
        end
    end

    // Wait counter clears on grant or when regs withdraws, otherwise saturates.
    always_comb begin
        wait_d = wait_q;
        if (!regs_sel_i || regs_granted) begin
            wait_d = '0;
        end else if (wait_q != {WAIT_W{1'b1}}) begin
            wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            mask_q      <= 4'h0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack_q       <= 3'b000;
            ptr_q       <= 2'd0;
            tag_owner_q <= OWN_NONE;
            tag_vgen_q  <= 1'b0;
            rd_owner_q  <= OWN_NONE;
            rd_vgen_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            ptr_q       <= ptr_d;
            tag_owner_q <= tag_owner_d;
            tag_vgen_q  <= tag_vgen_d;
            rd_owner_q  <= tag_owner_q;
            rd_vgen_q   <= tag_vgen_q;
            wait_q      <= wait_d;
        end
    end

    assign regs_ack_o      = ack_q[0];
    assign blit_ack_o      = ack_q[1];
    assign draw_ack_o      = ack_q[2];
    assign vram_sel_o      = sel_q;
    assign vram_wr_o       = wr_q;
    assign vram_wr_mask_o  = mask_q;
    assign vram_addr_o     = addr_q;
    assign vram_wdata_o    = wdata_q;
    assign rd_data_o       = vram_rdata_i;
    assign rd_owner_o      = rd_owner_q;
    assign vgen_rd_valid_o = rd_vgen_q;
    assign regs_wait_o     = wait_q;

endmodule

// File: tb/tb_vram_sched.sv
// Scoreboard bench for vram_sched: stimulus pushes expected VRAM accesses and
// read tags, a negedge monitor pops and compares them as the DUT presents them.
module tb_vram_sched;

    typedef struct packed {
        logic [15:0] cyc;
        logic        wr;
        logic [3:0]  mask;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  ack;
    } acc_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic [1:0]  owner;
        logic        vgen;
        logic [15:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        vgen_sel_i;
    logic [15:0] vgen_addr_i;
    logic        regs_sel_i, regs_wr_i;
    logic [3:0]  regs_wr_mask_i;
    logic [15:0] regs_addr_i, regs_data_i;
    logic        blit_sel_i, blit_wr_i;
    logic [3:0]  blit_wr_mask_i;
    logic [15:0] blit_addr_i, blit_data_i;
    logic        draw_sel_i, draw_wr_i;
    logic [3:0]  draw_wr_mask_i;
    logic [15:0] draw_addr_i, draw_data_i;
    logic [15:0] vram_rdata;

    logic        a_regs_ack, a_blit_ack, a_draw_ack, a_sel, a_wr, a_vvalid;
    logic [3:0]  a_mask;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_owner;
    logic [7:0]  a_wait;
    logic        b_regs_ack, b_blit_ack, b_draw_ack, b_sel, b_wr, b_vvalid;
    logic [3:0]  b_mask;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_owner;
    logic [7:0]  b_wait;

    logic        use_b = 1'b0;
    logic        m_sel, m_wr, m_vvalid;
    logic [3:0]  m_mask;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_owner;
    logic [2:0]  m_ack;

    logic [15:0] cyc = 16'd0;
    int          checks = 0;
    int          errors = 0;
    acc_t        acc_q[$];
    rd_t         rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    vram_sched #(.EN_BLIT(1'b1), .EN_DRAW(1'b1), .WAIT_W(8)) dut_a (
        .clk(clk), .reset_n_i(reset_n_i),
        .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
        .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wr_mask_i(regs_wr_mask_i),
        .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(a_regs_ack),
        .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wr_mask_i(blit_wr_mask_i),
        .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(a_blit_ack),
        .draw_sel_i(draw_sel_i), .draw_wr_i(draw_wr_i), .draw_wr_mask_i(draw_wr_mask_i),
        .draw_addr_i(draw_addr_i), .draw_data_i(draw_data_i), .draw_ack_o(a_draw_ack),
        .vram_sel_o(a_sel), .vram_wr_o(a_wr), .vram_wr_mask_o(a_mask),
        .vram_addr_o(a_addr), .vram_wdata_o(a_wdata), .vram_rdata_i(vram_rdata),
        .rd_data_o(a_rdata), .rd_owner_o(a_owner), .vgen_rd_valid_o(a_vvalid),
        .regs_wait_o(a_wait)
    );

    vram_sched dut_b (
        .clk(clk), .reset_n_i(reset_n_i),
        .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
        .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wr_mask_i(regs_wr_mask_i),
        .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(b_regs_ack),
        .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wr_mask_i(blit_wr_mask_i),
        .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(b_blit_ack),
        .draw_sel_i(draw_sel_i), .draw_wr_i(draw_wr_i), .draw_wr_mask_i(draw_wr_mask_i),
        .draw_addr_i(draw_addr_i), .draw_data_i(draw_data_i), .draw_ack_o(b_draw_ack),
        .vram_sel_o(b_sel), .vram_wr_o(b_wr), .vram_wr_mask_o(b_mask),
        .vram_addr_o(b_addr), .vram_wdata_o(b_wdata), .vram_rdata_i(vram_rdata),
        .rd_data_o(b_rdata), .rd_owner_o(b_owner), .vgen_rd_valid_o(b_vvalid),
        .regs_wait_o(b_wait)
    );

    assign m_sel    = use_b ? b_sel    : a_sel;
    assign m_wr     = use_b ? b_wr     : a_wr;
    assign m_mask   = use_b ? b_mask   : a_mask;
    assign m_addr   = use_b ? b_addr   : a_addr;
    assign m_wdata  = use_b ? b_wdata  : a_wdata;
    assign m_rdata  = use_b ? b_rdata  : a_rdata;
    assign m_owner  = use_b ? b_owner  : a_owner;
    assign m_vvalid = use_b ? b_vvalid : a_vvalid;
    assign m_ack    = use_b ? {b_draw_ack, b_blit_ack, b_regs_ack}
                            : {a_draw_ack, a_blit_ack, a_regs_ack};

    // VRAM model: registered read, 0xBEEF at 0x0010, otherwise addr ^ 0x5A5A.
    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vram_rdata <= 16'h0000;
        end else if (m_sel && !m_wr) begin
            vram_rdata <= (m_addr == 16'h0010) ? 16'hBEEF : (m_addr ^ 16'h5A5A);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vg, input logic rg, input logic bl, input logic dr);
        vgen_sel_i = vg;
        regs_sel_i = rg;
        blit_sel_i = bl;
        draw_sel_i = dr;
    endtask

    task automatic expectAccess(input logic wr, input logic [3:0] mask, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [2:0] ack);
        acc_q.push_back('{cyc: cyc + 16'd1, wr: wr, mask: mask, addr: addr, wdata: wdata, ack: ack});
    endtask

    task automatic expectRead(input logic [1:0] owner, input logic vg, input logic [15:0] data);
        rd_q.push_back('{cyc: cyc + 16'd2, owner: owner, vgen: vg, data: data});
    endtask

    always @(negedge clk) begin
        acc_t ea;
        rd_t  er;
        if (m_sel) begin
            if (acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_access cyc=%0d addr=%h ack=%b required=none", cyc, m_addr, m_ack);
            end else begin
                ea = acc_q.pop_front();
                checkOutput("access",
                    {8'h0, cyc, m_wr, m_mask, m_addr, (ea.wr ? m_wdata : 16'h0), m_ack},
                    {8'h0, ea.cyc, ea.wr, ea.mask, ea.addr, (ea.wr ? ea.wdata : 16'h0), ea.ack});
            end
        end else begin
            checkOutput("idle_ack_wr", {60'h0, m_ack, m_wr}, 64'h0);
        end
        if (m_owner != 2'd0 || m_vvalid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read_tag cyc=%0d owner=%0d vgen=%b required=none", cyc, m_owner, m_vvalid);
            end else begin
                er = rd_q.pop_front();
                checkOutput("read_tag", {29'h0, cyc, m_owner, m_vvalid, m_rdata},
                                        {29'h0, er.cyc, er.owner, er.vgen, er.data});
            end
        end
    end

    initial begin
        reset_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        vgen_addr_i = 16'h0;
        regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0; regs_addr_i = 16'h0; regs_data_i = 16'h0;
        blit_wr_i = 1'b0; blit_wr_mask_i = 4'h0; blit_addr_i = 16'h0; blit_data_i = 16'h0;
        draw_wr_i = 1'b0; draw_wr_mask_i = 4'h0; draw_addr_i = 16'h0; draw_data_i = 16'h0;
        repeat (3) tick();
        checkOutput("reset_vram", {26'h0, a_sel, a_wr, a_mask, a_addr, a_wdata}, 64'h0);
        checkOutput("reset_misc", {34'h0, a_rdata, a_owner, a_vvalid, a_regs_ack, a_blit_ack, a_draw_ack, a_wait}, 64'h0);
        reset_n_i = 1'b1;
        tick();

        $display("[TB] vgen priority with regs starved");
        vgen_addr_i = 16'h1234;
        regs_addr_i = 16'h0500;
        for (int k = 0; k < 260; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            expectAccess(1'b0, 4'h0, 16'h1234, 16'h0, 3'b000);
            expectRead(2'd0, 1'b1, 16'h486E);
            if (k == 0 || k == 1 || k == 100 || k == 255 || k == 259)
                checkOutput("regs_wait", {56'h0, a_wait}, (k > 255) ? 64'd255 : 64'(k));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("regs_wait_clear", {56'h0, a_wait}, 64'h0);
        repeat (2) tick();

        $display("[TB] three-way round robin writes");
        regs_wr_i = 1'b1; regs_wr_mask_i = 4'hF; regs_addr_i = 16'h0100; regs_data_i = 16'h1111;
        blit_wr_i = 1'b1; blit_wr_mask_i = 4'h3; blit_addr_i = 16'h0200; blit_data_i = 16'h2222;
        draw_wr_i = 1'b1; draw_wr_mask_i = 4'hC; draw_addr_i = 16'h0300; draw_data_i = 16'h3333;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            case (k % 3)
                0:       expectAccess(1'b1, 4'hF, 16'h0100, 16'h1111, 3'b001);
                1:       expectAccess(1'b1, 4'h3, 16'h0200, 16'h2222, 3'b010);
                default: expectAccess(1'b1, 4'hC, 16'h0300, 16'h3333, 3'b100);
            endcase
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] single regs read");
        regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0; regs_addr_i = 16'h0010; regs_data_i = 16'h0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectAccess(1'b0, 4'h0, 16'h0010, 16'h0, 3'b001);
        expectRead(2'd1, 1'b0, 16'hBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] blit alone held");
        blit_wr_i = 1'b1; blit_wr_mask_i = 4'hF; blit_addr_i = 16'h0400; blit_data_i = 16'hA5A5;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (k % 2 == 0)
                expectAccess(1'b1, 4'hF, 16'h0400, 16'hA5A5, 3'b010);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] draw disabled instance");
        use_b = 1'b1;
        regs_wr_i = 1'b1; regs_wr_mask_i = 4'h5; regs_addr_i = 16'h0600; regs_data_i = 16'h6666;
        draw_wr_i = 1'b1; draw_wr_mask_i = 4'hF; draw_addr_i = 16'h0700; draw_data_i = 16'h7777;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            if (k % 2 == 0)
                expectAccess(1'b1, 4'h5, 16'h0600, 16'h6666, 3'b001);
            if (k == 2) checkOutput("b_regs_wait_gap", {56'h0, b_wait}, 64'd1);
            if (k == 3) checkOutput("b_regs_wait_grant", {56'h0, b_wait}, 64'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        use_b = 1'b0;
        tick();

        $display("[TB] reset during in-flight regs read");
        regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0; regs_addr_i = 16'h0010;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        reset_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("midreset_vram", {26'h0, a_sel, a_wr, a_mask, a_addr, a_wdata}, 64'h0);
        checkOutput("midreset_misc", {34'h0, a_rdata, a_owner, a_vvalid, a_regs_ack, a_blit_ack, a_draw_ack, a_wait}, 64'h0);
        repeat (2) tick();
        reset_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("post_reset_tag", {59'h0, a_owner, a_vvalid, a_regs_ack, a_sel}, 64'h0);
        end

        checkOutput("acc_queue_drained", 64'(acc_q.size()), 64'h0);
        checkOutput("rd_queue_drained", 64'(rd_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_sched.md
Name: vram_sched

Overview:
- Single-port VRAM access scheduler for the Xosera core, sitting between the VRAM requesters and the VRAM block.
- Video generation (vgen) has absolute priority and never stalls.
- The register interface (regs), blitter (blit) and draw unit share the remaining slots round-robin.
- Accesses are pipelined: requests are sampled in cycle N, presented to VRAM in N+1, and read data returns in N+2 with an owner tag.

Parameters:
- EN_BLIT, 1, blit requester present; when 0, blit_sel_i is ignored and blit_ack_o is tied 0.
- EN_DRAW, 0, draw requester present; when 0, draw_sel_i is ignored and draw_ack_o is tied 0.
- WAIT_W, 8, width of the saturating regs wait counter.

Ports:
- clk  in  1  pixel clock.
- reset_n_i  in  1  asynchronous active-low reset.
- vgen_sel_i  in  1  vgen read request; served in the same pipeline slot, no ack.
- vgen_addr_i  in  16  vgen read address.
- regs_sel_i  in  1  regs request; held until ack.
- regs_wr_i  in  1  regs write (1) / read (0).
- regs_wr_mask_i  in  4  regs nibble write mask.
- regs_addr_i  in  16  regs address.
- regs_data_i  in  16  regs write data.
- regs_ack_o  out  1  regs request accepted.
- blit_sel_i, blit_wr_i, blit_wr_mask_i, blit_addr_i, blit_data_i, blit_ack_o: same widths and meaning as the regs group.
- draw_sel_i, draw_wr_i, draw_wr_mask_i, draw_addr_i, draw_data_i, draw_ack_o: same widths and meaning as the regs group.
- vram_sel_o  out  1  VRAM access strobe.
- vram_wr_o  out  1  VRAM write enable.
- vram_wr_mask_o  out  4  VRAM nibble mask.
- vram_addr_o  out  16  VRAM address.
- vram_wdata_o  out  16  VRAM write data.
- vram_rdata_i  in  16  VRAM read data, valid one cycle after a read strobe.
- rd_data_o  out  16  read data broadcast to all requesters.
- rd_owner_o  out  2  owner of rd_data_o: 0 none, 1 regs, 2 blit, 3 draw; vgen reads report 0.
- vgen_rd_valid_o  out  1  rd_data_o belongs to vgen.
- regs_wait_o  out  WAIT_W  saturating count of cycles the current regs request has waited.

Behaviour:
- Reset (async, active low):
  - All outputs are 0.
  - The round-robin pointer is set to regs.
  - The ack, owner and valid pipelines are cleared.
  - An in-flight access is discarded; no ack or valid pulse follows reset release.
- Cycle N arbitration (combinational):
  - If vgen_sel_i is 1, vgen wins.
  - Otherwise the winner is the first eligible requester in rotation order, starting at the pointer (regs -> blit -> draw -> regs).
  - Eligible means sel is 1, the unit is enabled, and its ack is not high this cycle.
- Edge ending cycle N: the winner's sel/wr/mask/addr/data are registered onto the vram_* outputs.
  - vgen accesses force vram_wr_o=0 and vram_wr_mask_o=0.
  - With no winner: vram_sel_o=0, vram_wr_o=0, and addr/data/mask hold their previous values.
- Cycle N+1:
  - The winner's ack_o pulses high for exactly one cycle; the requester may drop or change sel in N+1.
  - The pointer moves to the requester after the winner. It does not move on vgen or idle cycles.
- Cycle N+2, for a read:
  - rd_data_o = vram_rdata_i, combinational pass-through.
  - rd_owner_o or vgen_rd_valid_o is registered from N+1 and valid for one cycle.
  - Writes produce no owner tag.
- Back-to-back operation:
  - A new grant can be issued every cycle, for 100% VRAM utilisation.
  - A requester holding sel continuously is granted at most every other cycle because of ack masking. Another requester fills the gap.
- Simultaneous vgen and others: others wait; acks are not delayed for in-flight grants.
- regs_wait_o:
  - Increments each cycle regs_sel_i=1 and regs is not granted.
  - Saturates at 2^WAIT_W-1.
  - Clears on the cycle regs is granted and whenever regs_sel_i=0.
- Disabled units (EN_*=0): the unit never wins, its ack stays 0, and the rotation skips it.

Decomposition:
- Package xv:
  - addr_t and word_t, already present.
  - New enum vram_owner_t {OWN_NONE=0, OWN_REGS, OWN_BLIT, OWN_DRAW}.
- Sub-module vram_rr_pick: combinational 3-way rotating priority picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: one-hot grant and owner.
  - Pointer state stays in vram_sched.

Test Plan:
- Reset released, vgen_sel_i=1 at addr 0x1234 every cycle, regs_sel_i=1 -> vram_addr_o=0x1234 each cycle, regs_ack_o stays 0, regs_wait_o counts to 255 and holds.
- Idle, then regs read of 0x0010 in cycle 0 with VRAM model returning 0xBEEF -> vram_sel_o=1 and addr 0x0010 in cycle 1; regs_ack_o=1 in cycle 1; rd_data_o=0xBEEF with rd_owner_o=1 in cycle 2.
- regs, blit and draw all held requesting, no vgen -> grant order regs, blit, draw, regs, blit, draw; one ack per cycle; vram_sel_o continuously 1.
- blit alone held requesting writes to mask 0xF -> blit_ack_o pulses on alternate cycles; vram_wr_o=1 on grant cycles only.
- EN_DRAW=0 with draw_sel_i=1 and regs requesting -> draw never acked; regs served every other cycle.
- reset_n_i asserted low in the cycle after a regs read grant -> no regs_ack_o, all outputs 0 immediately, rd_owner_o=0 after release.
